// File: rtl/ws2812_tx_if.sv
// Frame handshake between a pixel source and the WS2812 serialiser.
interface ws2812_tx_if #(
   parameter int unsigned NUM_LEDS = 16
);
   logic [NUM_LEDS*24-1:0] frame_data;
   logic                   start;
   logic                   ready;
   logic                   done;

   modport master (output frame_data, output start, input ready, input done);
   modport slave  (input frame_data, input start, output ready, output done);
endinterface

// File: rtl/ws2812_tx.sv
// WS2812 serial transmitter: shifts a captured GRB frame out as pulse-width coded bits,
// then holds the line low for the latch gap and pulses done.
module ws2812_tx #(
   parameter int unsigned NUM_LEDS = 16,
   parameter int unsigned T0H      = 50,
   parameter int unsigned T1H      = 100,
   parameter int unsigned TBIT     = 156,
   parameter int unsigned TLATCH   = 7500
) (
   input  logic        clk,
   input  logic        rst_n,
   ws2812_tx_if.slave  bus,
   output logic        ws2812_din_o
);

   localparam int unsigned NumBits = NUM_LEDS * 24;
   localparam int unsigned BitW    = (NumBits > 1) ? $clog2(NumBits) : 1;
   localparam int unsigned CntMax  = (TBIT > TLATCH) ? TBIT : TLATCH;
   localparam int unsigned CntW    = $clog2(CntMax + 1);

   typedef enum logic [1:0] {StIdle, StHigh, StLow, StLatch} state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [BitW-1:0]      bit_q, bit_d;
   logic [NumBits-1:0]   shadow_q, shadow_d;
   logic [NumBits-1:0]   frame_ordered;
   logic                 din_q, din_d;
   logic                 ready, done;
   logic                 accept, cur_bit, high_end, bit_end, last_bit, latch_end;

   // Reorder so the first bit on the wire (pixel 0, bit 23) sits at the shadow MSB.
   always_comb begin
      frame_ordered = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         frame_ordered[(NUM_LEDS-1-i)*24 +: 24] = bus.frame_data[i*24 +: 24];
      end
   end

   assign accept    = (state_q == StIdle) && bus.start;
   assign cur_bit   = shadow_q[NumBits-1];
   assign high_end  = cnt_q == (cur_bit ? CntW'(T1H - 1) : CntW'(T0H - 1));
   assign bit_end   = cnt_q == CntW'(TBIT - 1);
   assign last_bit  = bit_q == BitW'(NumBits - 1);
   assign latch_end = cnt_q == CntW'(TLATCH - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept)    state_d = StHigh;
         StHigh:  if (high_end)  state_d = StLow;
         StLow:   if (bit_end)   state_d = last_bit ? StLatch : StHigh;
         StLatch: if (latch_end) state_d = StIdle;
         default:                state_d = StIdle;
      endcase
   end

   // Phase counter runs across the whole bit period; high/low split is a compare point.
   always_comb begin
      cnt_d    = cnt_q + 1'b1;
      bit_d    = bit_q;
      shadow_d = shadow_q;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            bit_d = '0;
            if (accept) shadow_d = frame_ordered;
         end
         StLow: begin
            if (bit_end) begin
               cnt_d = '0;
               if (!last_bit) begin
                  bit_d    = bit_q + 1'b1;
                  shadow_d = {shadow_q[NumBits-2:0], 1'b0};
               end
            end
         end
         StLatch: if (latch_end) cnt_d = '0;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         bit_q    <= '0;
         shadow_q <= '0;
         din_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shadow_q <= shadow_d;
         din_q    <= din_d;
      end
   end

   always_comb begin
      din_d = (state_d == StHigh);
      ready = (state_q == StIdle);
      done  = (state_q == StLatch) && latch_end;
   end

   assign bus.ready    = ready;
   assign bus.done     = done;
   assign ws2812_din_o = din_q;

endmodule

// File: tb/tb_ws2812_tx.sv
// Randomised bench: a frame-level timing model feeds a scoreboard; a line decoder checks it.
module tb_ws2812_tx;

   localparam int unsigned NL   = 2;
   localparam int unsigned T0   = 5;
   localparam int unsigned T1   = 10;
   localparam int unsigned TB   = 16;
   localparam int unsigned TL   = 40;
   localparam int unsigned BITS = NL * 24;
   localparam int          F    = BITS * TB + TL;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic din;

   ws2812_tx_if #(.NUM_LEDS(NL)) bus ();

   ws2812_tx #(
      .NUM_LEDS(NL),
      .T0H     (T0),
      .T1H     (T1),
      .TBIT    (TB),
      .TLATCH  (TL)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .ws2812_din_o(din)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int busy_until = 0;
   logic [BITS-1:0] exp_q[$];
   int              acc_q[$];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [BITS-1:0] rnd_frame();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) r = '1;
      return r[BITS-1:0];
   endfunction

   // Reference: a frame occupies F cycles from its accept edge; starts while busy are dropped.
   always @(posedge clk or negedge rst_n) begin : model
      bit idle;
      if (!rst_n) begin
         busy_until = 0;
      end else begin
         idle = (cyc >= busy_until);
         cyc  = cyc + 1;
         if (idle && bus.start) begin
            exp_q.push_back(bus.frame_data);
            acc_q.push_back(cyc);
            busy_until = cyc + F;
         end
      end
   end

   logic            prev_din = 1'b0;
   int              hi_len = 0;
   int              nbits = 0;
   int              last_rise = 0;
   logic [BITS-1:0] acc = '0;

   always @(negedge clk) begin : monitor
      bit              b;
      logic [BITS-1:0] e;
      chk("ready", bus.ready, cyc >= busy_until);
      chk("done", bus.done, cyc == busy_until - 1);
      if (!rst_n) begin
         chk("din_in_reset", din, 0);
         exp_q.delete();
         acc_q.delete();
         nbits    = 0;
         hi_len   = 0;
         prev_din = 1'b0;
      end else begin
         if (din && !prev_din) begin
            if (nbits == 0) begin
               if (acc_q.size() == 0) chk("unexpected_frame_start", 1, 0);
               else chk("first_rise_cycle", cyc, acc_q.pop_front());
            end else begin
               chk("bit_period", cyc - last_rise, TB);
            end
            last_rise = cyc;
            hi_len    = 1;
         end else if (din) begin
            hi_len++;
         end else if (prev_din) begin
            b = (hi_len > (T0 + T1) / 2);
            chk("high_width", hi_len, b ? T1 : T0);
            acc = {acc[BITS-2:0], b};
            nbits++;
            if (nbits == BITS) begin
               if (exp_q.size() == 0) begin
                  chk("frame_without_expectation", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  for (int i = 0; i < NL; i++) begin
                     chk("pixel_grb", acc[BITS-1-24*i -: 24], e[24*i +: 24]);
                  end
               end
               nbits = 0;
            end
         end
         prev_din = din;
      end
   end

   task automatic random_phase(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.frame_data = rnd_frame();
         bus.start      = ($urandom_range(0, 31) == 0);
      end
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   initial begin
      bus.start      = 1'b0;
      bus.frame_data = '0;
      repeat (3) @(posedge clk);

      // Start already high as reset releases: first edge after release must accept.
      @(negedge clk);
      bus.frame_data = rnd_frame();
      bus.start      = 1'b1;
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;

      random_phase(6000);
      repeat (F + 5) @(negedge clk);

      // Back-to-back frames with data churning every cycle.
      repeat (2500) begin
         @(negedge clk);
         bus.frame_data = rnd_frame();
         bus.start      = 1'b1;
      end
      @(negedge clk);
      bus.start = 1'b0;
      repeat (F + 5) @(negedge clk);

      // Abort mid-frame, then a clean frame must follow.
      @(negedge clk);
      bus.frame_data = rnd_frame();
      bus.start      = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (20 * TB + 3) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      bus.frame_data = rnd_frame();
      bus.start      = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;

      random_phase(3000);
      repeat (F + 5) @(negedge clk);

      @(posedge clk);
      #1;
      chk("pending_frames", exp_q.size(), 0);
      chk("partial_bits", nbits, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
